rd_burst_sched: RTL and testbench
=================================

# rd_burst_sched

Read-burst scheduler in front of the DDR2 read path and the rd_fifo. It arbitrates read requests from two requesters round-robin and issues one read command per grant to the DDR2 controller. Issue is throttled on rd_fifo almost_full and on a cap of outstanding bursts. Each returning data beat is tagged with the ID of the requester that owns it. The block runs entirely in the DDR2 user clock domain, which is the rd_fifo write-clock side.

## Interface
- ADDR_WIDTH, 31, read address width.
- BURST_BEATS, 2, data beats returned per read command (power of two, 1..8).
- MAX_OUTST, 8, maximum bursts issued but not fully returned (power of two, 2..16).

Ports:
- clk  in  1  DDR2 user clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-requester read request level; held until granted.
- req_addr0  in  ADDR_WIDTH  requester 0 address; stable while req[0]=1.
- req_addr1  in  ADDR_WIDTH  requester 1 address; stable while req[1]=1.
- gnt  out  2  one-hot, one-cycle pulse; the request is accepted on this cycle.
- cmd_valid  out  1  read command valid to the DDR2 controller.
- cmd_addr  out  ADDR_WIDTH  read command address.
- cmd_ready  in  1  the controller accepts the command when cmd_valid and cmd_ready are both 1.
- rd_data_vd  in  1  read data beat valid; the same signal drives the rd_fifo write enable.
- fifo_almost_full  in  1  rd_fifo almost_full, in the clk domain.
- rtn_vd  out  1  registered copy of rd_data_vd.
- rtn_id  out  1  owner ID of the beat flagged by rtn_vd.
- rtn_last  out  1  the beat flagged by rtn_vd is the final beat of its burst.
- outstanding  out  $clog2(MAX_OUTST)+1  count of bursts in flight.
- busy  out  1  high when the state is not IDLE or outstanding≠0.
- err  out  1  sticky error flag (see Configuration).

## Operation
- FSM states: IDLE, GRANT, ISSUE.
- IDLE → GRANT when all three hold: req≠0, outstanding<MAX_OUTST, fifo_almost_full=0.
- GRANT lasts one cycle:
  - gnt pulses for the winner.
  - The winner's address is latched into cmd_addr.
  - The winner's ID is latched.
  - Next state is ISSUE.
- Round-robin arbitration: a last-winner pointer resets to 1, so requester 0 has priority first. If only one requester is active, it wins. If both are active, the one that is not the last winner wins. The pointer updates in GRANT.
- ISSUE: cmd_valid=1 and cmd_addr is held until cmd_ready=1. On that handshake:
  - the ID is pushed into the tag FIFO (depth MAX_OUTST);
  - outstanding increments;
  - next state is IDLE.
- fifo_almost_full is sampled only in IDLE. A command already in ISSUE always completes.
- Return path:
  - The beat counter counts rd_data_vd modulo BURST_BEATS.
  - rtn_id is the head of the tag FIFO.
  - rtn_last=1 when the beat counter equals BURST_BEATS-1.
  - On the last beat the tag FIFO pops and outstanding decrements.
- If a command handshake and a last beat occur in the same cycle, outstanding is unchanged and the tag FIFO pushes and pops at once.
- The tag FIFO cannot overflow, because issue is gated by outstanding<MAX_OUTST.

## Timing
- Reset values:
  - state=IDLE;
  - gnt=0, cmd_valid=0, cmd_addr=0;
  - rtn_vd=0, rtn_id=0, rtn_last=0;
  - outstanding=0, busy=0, err=0;
  - beat counter=0, tag FIFO empty.
- Request-to-command latency: with req high in IDLE at cycle N, gnt pulses at N+1 and cmd_valid first asserts at N+2.
- Minimum command spacing is 3 cycles (IDLE, GRANT, ISSUE with cmd_ready already high).
- rtn_vd, rtn_id and rtn_last lag rd_data_vd by exactly 1 cycle.
- outstanding updates the cycle after the handshake or the last beat.
- Reset may be asserted mid-burst. It clears all state immediately. Beats still returning afterwards are counted from beat 0 with an empty tag FIFO.

## Configuration
- RD_SCHED_ERR_CHK_EN defined:
  - err sets and stays at 1 until reset if rd_data_vd=1 while the tag FIFO is empty.
  - For that erroneous beat, rtn_vd still pulses with rtn_id=0, and outstanding does not underflow (it stays at 0).
- RD_SCHED_ERR_CHK_EN not defined: err is tied to 0 and no check logic is built.

## Test plan
- Single request: req=01, addr0=0x100, cmd_ready=1 → gnt=01 at N+1; cmd_valid with cmd_addr=0x100 at N+2; outstanding=1; two beats return → rtn_id=0, rtn_last on beat 2, outstanding=0.
- Contention: req=11 held, addresses 0x10/0x20 → grants alternate 01,10,01,10; cmd_addr alternates 0x10,0x20; return tags follow the same 0,1,0,1 order.
- Credit cap: no returns, req=01 held → exactly 8 commands issued, outstanding=8, no further gnt; one full burst returns → the next gnt follows.
- Backpressure: fifo_almost_full=1 in IDLE → no gnt; cmd_ready=0 for 5 cycles in ISSUE → cmd_valid and cmd_addr held stable, a single handshake.
- Simultaneous events: handshake in the same cycle as a last beat with outstanding=3 → outstanding stays 3 and the tag order is preserved.
- Error (RD_SCHED_ERR_CHK_EN defined): rd_data_vd with outstanding=0 → err=1 next cycle and stays 1; after reset, err=0.

Source files
------------

// File: rtl/rd_burst_sched.sv
`default_nettype none
//==============================================================================
// Module   : rd_burst_sched
// Brief    : Two-requester round-robin read-burst scheduler for the DDR2 read
//            path; tags each returning beat with its owner ID. Optional error
//            check on orphan beats is enabled by defining RD_SCHED_ERR_CHK_EN.
// Revision : 1.0 - initial release
//==============================================================================
module rd_burst_sched #(
    parameter int ADDR_WIDTH  = 31,
    parameter int BURST_BEATS = 2,
    parameter int MAX_OUTST   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req,
    input  logic [ADDR_WIDTH-1:0]        req_addr0,
    input  logic [ADDR_WIDTH-1:0]        req_addr1,
    output logic [1:0]                   gnt,
    output logic                         cmd_valid,
    output logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic                         cmd_ready,
    input  logic                         rd_data_vd,
    input  logic                         fifo_almost_full,
    output logic                         rtn_vd,
    output logic                         rtn_id,
    output logic                         rtn_last,
    output logic [$clog2(MAX_OUTST):0]   outstanding,
    output logic                         busy,
    output logic                         err
);

    localparam int c_PTR_W  = $clog2(MAX_OUTST);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    localparam logic [c_CNT_W-1:0]  c_MAX_OUTST = c_CNT_W'(MAX_OUTST);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_BEATS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last_win;
    logic                  r_id;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_outst;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_rtn_vd;
    logic                  r_rtn_id;
    logic                  r_rtn_last;
    logic                  r_tag_mem [MAX_OUTST];

    logic                  w_start;
    logic                  w_win;
    logic                  w_hs;
    logic                  w_tag_empty;
    logic                  w_last_beat;
    logic                  w_pop;
    logic                  w_head;

    // Credit and almost_full are only consulted here; a command past IDLE always completes.
    assign w_start     = (r_state == c_ST_IDLE) && (req != 2'b00) &&
                         (r_outst < c_MAX_OUTST) && !fifo_almost_full;
    assign w_hs        = (r_state == c_ST_ISSUE) && cmd_ready;
    assign w_tag_empty = (r_outst == '0);
    assign w_last_beat = rd_data_vd && (r_beat == c_LAST_BEAT);
    assign w_pop       = w_last_beat && !w_tag_empty;
    assign w_head      = w_tag_empty ? 1'b0 : r_tag_mem[r_rd_ptr];

    // Single requester wins outright; on contention the previous loser wins.
    always_comb begin
        w_win = ~r_last_win;
        if (req == 2'b01) begin
            w_win = 1'b0;
        end else if (req == 2'b10) begin
            w_win = 1'b1;
        end
    end

    assign gnt         = (r_state == c_ST_GRANT) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign cmd_valid   = (r_state == c_ST_ISSUE);
    assign cmd_addr    = r_cmd_addr;
    assign rtn_vd      = r_rtn_vd;
    assign rtn_id      = r_rtn_id;
    assign rtn_last    = r_rtn_last;
    assign outstanding = r_outst;
    assign busy        = (r_state != c_ST_IDLE) || (r_outst != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_last_win <= 1'b1;
            r_id       <= 1'b0;
            r_cmd_addr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    r_state    <= c_ST_ISSUE;
                    r_cmd_addr <= w_win ? req_addr1 : req_addr0;
                    r_id       <= w_win;
                    r_last_win <= w_win;
                end
                c_ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Tag storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_tag_mem[r_wr_ptr] <= r_id;
        end
    end

    // Tag FIFO occupancy is the outstanding-burst count itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_outst  <= '0;
        end else begin
            if (w_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_hs, w_pop})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat     <= '0;
            r_rtn_vd   <= 1'b0;
            r_rtn_id   <= 1'b0;
            r_rtn_last <= 1'b0;
        end else begin
            r_rtn_vd   <= rd_data_vd;
            r_rtn_last <= w_last_beat;
            if (rd_data_vd) begin
                r_rtn_id <= w_head;
                r_beat   <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
        end
    end

`ifdef RD_SCHED_ERR_CHK_EN
    logic r_err;

    // A beat arriving with no burst in flight has no owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (rd_data_vd && w_tag_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_burst_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_rd_burst_sched
// Brief    : Directed scoreboard bench for rd_burst_sched (grants, commands and
//            tagged returns are queued as issued and checked by a monitor).
// Revision : 1.0 - initial release
//==============================================================================
module tb_rd_burst_sched;

    localparam int c_AW    = 31;
    localparam int c_BEATS = 2;
    localparam int c_MAXO  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [c_AW-1:0] req_addr0;
    logic [c_AW-1:0] req_addr1;
    logic [1:0]      gnt;
    logic            cmd_valid;
    logic [c_AW-1:0] cmd_addr;
    logic            cmd_ready;
    logic            rd_data_vd;
    logic            fifo_almost_full;
    logic            rtn_vd;
    logic            rtn_id;
    logic            rtn_last;
    logic [3:0]      outstanding;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    rd_burst_sched #(
        .ADDR_WIDTH  (c_AW),
        .BURST_BEATS (c_BEATS),
        .MAX_OUTST   (c_MAXO)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_addr0        (req_addr0),
        .req_addr1        (req_addr1),
        .gnt              (gnt),
        .cmd_valid        (cmd_valid),
        .cmd_addr         (cmd_addr),
        .cmd_ready        (cmd_ready),
        .rd_data_vd       (rd_data_vd),
        .fifo_almost_full (fifo_almost_full),
        .rtn_vd           (rtn_vd),
        .rtn_id           (rtn_id),
        .rtn_last         (rtn_last),
        .outstanding      (outstanding),
        .busy             (busy),
        .err              (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_gnt_seen = 0;
    int n_hs_seen = 0;

    logic [1:0]      q_gnt [$];
    logic [c_AW-1:0] q_cmd [$];
    logic [1:0]      q_rtn [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, command or beat.
    always @(negedge clk) begin
        if (reset) begin
            if (gnt != 2'b00) begin
                n_gnt_seen++;
                if (q_gnt.size() == 0) chk("gnt_unexpected", gnt, 2'b00);
                else                   chk("gnt", gnt, q_gnt.pop_front());
            end
            if (cmd_valid && cmd_ready) begin
                n_hs_seen++;
                if (q_cmd.size() == 0) chk("cmd_unexpected", cmd_addr, '1);
                else                   chk("cmd_addr", cmd_addr, q_cmd.pop_front());
            end
            if (rtn_vd) begin
                if (q_rtn.size() == 0) chk("rtn_unexpected", {rtn_id, rtn_last}, 2'b11 ^ {rtn_id, rtn_last});
                else                   chk("rtn_id_last", {rtn_id, rtn_last}, q_rtn.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("queues_empty_before_reset", q_gnt.size() + q_cmd.size() + q_rtn.size(), 0);
        req = 2'b00;
        rd_data_vd = 1'b0;
        fifo_almost_full = 1'b0;
        cmd_ready = 1'b1;
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic wait_gnt(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (gnt == 2'b00 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_gnt_seen"}, (gnt != 2'b00), 1);
        cyc();
    endtask

    task automatic wait_outst(input string name, input int val);
        int k;
        k = 0;
        @(negedge clk);
        while (outstanding != val[3:0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_outstanding"}, outstanding, val);
        cyc();
    endtask

    task automatic send_burst(input logic id);
        for (int b = 0; b < c_BEATS; b++) begin
            q_rtn.push_back({id, (b == c_BEATS - 1) ? 1'b1 : 1'b0});
            rd_data_vd = 1'b1;
            cyc();
        end
        rd_data_vd = 1'b0;
    endtask

    task automatic issue_one(input int idx, input logic [c_AW-1:0] addr);
        int h0;
        int k;
        q_gnt.push_back(idx == 1 ? 2'b10 : 2'b01);
        q_cmd.push_back(addr);
        if (idx == 1) req_addr1 = addr;
        else          req_addr0 = addr;
        req[idx] = 1'b1;
        h0 = n_hs_seen;
        wait_gnt("issue");
        req[idx] = 1'b0;
        k = 0;
        @(negedge clk);
        while (n_hs_seen == h0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("issue_handshake", n_hs_seen - h0, 1);
        cyc();
    endtask

    initial begin
        int g0;
        int h0;

        reset = 1'b0;
        req = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        cmd_ready = 1'b1;
        rd_data_vd = 1'b0;
        fifo_almost_full = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_rtn", {rtn_vd, rtn_id, rtn_last}, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        do_reset();

        // Single request: latency and two-beat return
        req_addr0 = 31'h100;
        req = 2'b01;
        q_gnt.push_back(2'b01);
        q_cmd.push_back(31'h100);
        @(negedge clk);
        chk("t1_gnt_N", gnt, 2'b00);
        @(negedge clk);
        chk("t1_gnt_N1", gnt, 2'b01);
        chk("t1_cmd_valid_N1", cmd_valid, 0);
        cyc();
        req = 2'b00;
        @(negedge clk);
        chk("t1_cmd_valid_N2", cmd_valid, 1);
        chk("t1_cmd_addr_N2", cmd_addr, 31'h100);
        cyc();
        @(negedge clk);
        chk("t1_outstanding", outstanding, 1);
        chk("t1_busy", busy, 1);
        cyc();
        q_rtn.push_back(2'b00);
        q_rtn.push_back(2'b01);
        rd_data_vd = 1'b1;
        @(negedge clk);
        chk("t1_rtn_lag_b0", rtn_vd, 0);
        cyc();
        @(negedge clk);
        chk("t1_rtn_b0", {rtn_vd, rtn_last}, 2'b10);
        cyc();
        rd_data_vd = 1'b0;
        @(negedge clk);
        chk("t1_rtn_b1", {rtn_vd, rtn_id, rtn_last}, 3'b101);
        chk("t1_outstanding_drain", outstanding, 0);
        cyc();
        @(negedge clk);
        chk("t1_rtn_done", rtn_vd, 0);
        chk("t1_busy_done", busy, 0);
        cyc();

        // Contention: grants alternate starting with requester 0
        do_reset();
        req_addr0 = 31'h10;
        req_addr1 = 31'h20;
        for (int i = 0; i < 4; i++) begin
            q_gnt.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            q_cmd.push_back((i % 2 == 0) ? 31'h10 : 31'h20);
        end
        req = 2'b11;
        for (int i = 0; i < 4; i++) wait_gnt("t2");
        req = 2'b00;
        wait_outst("t2_four", 4);
        send_burst(1'b0);
        send_burst(1'b1);
        send_burst(1'b0);
        send_burst(1'b1);
        wait_outst("t2_drain", 0);

        // Credit cap: eight commands, then stall until one burst returns
        do_reset();
        for (int i = 0; i < c_MAXO; i++) begin
            q_gnt.push_back(2'b01);
            q_cmd.push_back(31'h200);
        end
        g0 = n_gnt_seen;
        req_addr0 = 31'h200;
        req = 2'b01;
        repeat (40) cyc();
        chk("t3_gnt_count", n_gnt_seen - g0, c_MAXO);
        chk("t3_outstanding_cap", outstanding, c_MAXO);
        chk("t3_busy", busy, 1);
        q_gnt.push_back(2'b01);
        q_cmd.push_back(31'h200);
        g0 = n_gnt_seen;
        send_burst(1'b0);
        wait_gnt("t3_after_return");
        req = 2'b00;
        wait_outst("t3_refill", c_MAXO);
        chk("t3_one_more_gnt", n_gnt_seen - g0, 1);
        for (int i = 0; i < c_MAXO; i++) send_burst(1'b0);
        wait_outst("t3_drain", 0);

        // Backpressure: almost_full blocks grant; cmd_ready low holds command
        fifo_almost_full = 1'b1;
        req_addr1 = 31'h300;
        req = 2'b10;
        g0 = n_gnt_seen;
        repeat (6) cyc();
        chk("t4_no_gnt_af", n_gnt_seen - g0, 0);
        cmd_ready = 1'b0;
        q_gnt.push_back(2'b10);
        q_cmd.push_back(31'h300);
        fifo_almost_full = 1'b0;
        wait_gnt("t4");
        req = 2'b00;
        fifo_almost_full = 1'b1;
        h0 = n_hs_seen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid_addr", {cmd_valid, cmd_addr}, {1'b1, 31'h300});
            cyc();
        end
        cmd_ready = 1'b1;
        cyc();
        fifo_almost_full = 1'b0;
        @(negedge clk);
        chk("t4_cmd_valid_after", cmd_valid, 0);
        chk("t4_single_handshake", n_hs_seen - h0, 1);
        cyc();
        send_burst(1'b1);
        wait_outst("t4_drain", 0);

        // Handshake coincides with a last beat at outstanding=3
        do_reset();
        issue_one(0, 31'h400);
        issue_one(1, 31'h410);
        issue_one(0, 31'h420);
        wait_outst("t5_three", 3);
        cmd_ready = 1'b0;
        q_gnt.push_back(2'b10);
        q_cmd.push_back(31'h430);
        req_addr1 = 31'h430;
        req = 2'b10;
        wait_gnt("t5");
        req = 2'b00;
        q_rtn.push_back(2'b00);
        q_rtn.push_back(2'b01);
        rd_data_vd = 1'b1;
        @(negedge clk);
        chk("t5_cmd_valid", cmd_valid, 1);
        cyc();
        cmd_ready = 1'b1;
        cyc();
        rd_data_vd = 1'b0;
        @(negedge clk);
        chk("t5_outstanding_same", outstanding, 3);
        chk("t5_cmd_valid_done", cmd_valid, 0);
        cyc();
        send_burst(1'b1);
        send_burst(1'b0);
        send_burst(1'b1);
        wait_outst("t5_drain", 0);

        // Reset mid-burst: beat counter restarts from beat 0
        do_reset();
        issue_one(0, 31'h500);
        q_rtn.push_back(2'b00);
        rd_data_vd = 1'b1;
        cyc();
        rd_data_vd = 1'b0;
        cyc();
        cyc();
        do_reset();
        chk("t6_outstanding_after_reset", outstanding, 0);
        issue_one(1, 31'h510);
        send_burst(1'b1);
        wait_outst("t6_drain", 0);

`ifdef RD_SCHED_ERR_CHK_EN
        // Orphan beat sets sticky err; outstanding does not underflow
        do_reset();
        chk("t7_err_clear", err, 0);
        q_rtn.push_back(2'b00);
        rd_data_vd = 1'b1;
        cyc();
        rd_data_vd = 1'b0;
        @(negedge clk);
        chk("t7_err_set", err, 1);
        chk("t7_outstanding_no_underflow", outstanding, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("t7_err_sticky", err, 1);
        cyc();
        do_reset();
        @(negedge clk);
        chk("t7_err_after_reset", err, 0);
        cyc();
`else
        @(negedge clk);
        chk("t7_err_tied_low", err, 0);
        cyc();
`endif

        repeat (3) cyc();
        chk("end_queues_empty", q_gnt.size() + q_cmd.size() + q_rtn.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
